// File: rtl/data_mem.sv
// Word-addressed data memory with a fixed-latency request/response handshake.
// Optional byte-enable writes are compiled in with `define DATA_MEM_BYTE_WRITE_EN.
module data_mem #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [31:0]                req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/8-1:0]        req_be,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       resp_err,
    input  logic [$clog2(DEPTH)-1:0]   peek_addr,
    output logic [DATA_W-1:0]          peek_data
);

    localparam int         AW       = $clog2(DEPTH);
    localparam int         BE_W     = DATA_W / 8;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                enter_resp;
    logic                cur_we;
    logic [31:0]         cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [BE_W-1:0]     cur_be;
    logic [AW-1:0]       cur_idx;
    logic                cur_err;
    logic                mem_we;

    assign accept = req_valid && (state_q == S_IDLE);

    // With no wait states the commit happens on the accepting edge itself,
    // so the live request is used instead of the (not yet loaded) latch.
    assign enter_resp = (state_q == S_WAIT && cnt_q == '0) || (NO_WAIT && accept);
    assign cur_we     = (state_q == S_IDLE) ? req_we    : we_q;
    assign cur_addr   = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign cur_wdata  = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign cur_be     = (state_q == S_IDLE) ? req_be    : be_q;
    assign cur_idx    = cur_addr[AW+1:2];
    assign cur_err    = (|cur_addr[1:0]) || (|cur_addr[31:AW+2]);

    // A reset on the commit edge drops the pending write.
    assign mem_we = n_reset && enter_resp && cur_we && !cur_err;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid)  state_d = NO_WAIT ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
            cnt_d   = CNT_INIT;
        end else if (state_q == S_WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_we || cur_err) ? '0 : mem[cur_idx];
        end
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
`ifdef DATA_MEM_BYTE_WRITE_EN
            for (int i = 0; i < BE_W; i++) begin
                if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
`else
            mem[cur_idx] <= cur_wdata;
`endif
        end
    end

`ifndef DATA_MEM_BYTE_WRITE_EN
    logic unused_be;
    assign unused_be = ^cur_be;
`endif

    assign peek_data = mem[peek_addr];

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem (DATA_W=32, DEPTH=256, WAIT_CYCLES=2).
// Expected byte-write result follows DATA_MEM_BYTE_WRITE_EN when it is defined.
module tb_data_mem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int WAITC  = 2;
    localparam int LAT    = WAITC + 1;

    logic              clk = 1'b0;
    logic              n_reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [7:0]        peek_addr;
    logic [31:0]       peek_data;

    int total = 0;
    int bad   = 0;

    int          got_lat;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        ready_low;
    logic        idle_after;

`ifdef DATA_MEM_BYTE_WRITE_EN
    localparam logic [31:0] EXP_M1 = 32'h11BB33DD;
`else
    localparam logic [31:0] EXP_M1 = 32'hAABBCCDD;
`endif

    data_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .peek_addr  (peek_addr),
        .peek_data  (peek_data)
    );

    always #5 clk = ~clk;

    // One full access with resp_ready held high; results land in got_*.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_be     = be;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got_lat   = 0;
        got_rdata = 'x;
        got_err   = 1'bx;
        ready_low = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (req_ready !== 1'b0) ready_low = 1'b0;
            if (resp_valid === 1'b1) begin
                got_lat   = c;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                break;
            end
        end
        @(posedge clk);
        #1;
        idle_after = (req_ready === 1'b1) && (resp_valid === 1'b0);
    endtask

    task automatic peek(input logic [7:0] idx, output logic [31:0] val);
        peek_addr = idx;
        #1;
        val = peek_data;
    endtask

    task automatic test_reset;
        n_reset    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        resp_ready = 1'b1;
        peek_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b err=%b rdata=%h want 0/0/0",
                     resp_valid, resp_err, resp_rdata);
        end
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_write;
        logic [31:0] v;
        issue(1'b1, 32'h0, 32'h00000037, 4'hF);
        total++;
        if (got_lat !== LAT || got_err !== 1'b0 || got_rdata !== 32'h0) begin
            bad++;
            $display("FAIL write_resp: got lat=%0d err=%b rdata=%h want lat=%0d err=0 rdata=0",
                     got_lat, got_err, got_rdata, LAT);
        end
        peek(8'd0, v);
        total++;
        if (v !== 32'h37) begin
            bad++;
            $display("FAIL write_mem0: got %h want 00000037", v);
        end
        total++;
        if (idle_after !== 1'b1) begin
            bad++;
            $display("FAIL write_idle: got %b want 1", idle_after);
        end
    endtask

    task automatic test_read;
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        total++;
        if (got_lat !== LAT || got_err !== 1'b0 || got_rdata !== 32'h37) begin
            bad++;
            $display("FAIL read_resp: got lat=%0d err=%b rdata=%h want lat=%0d err=0 rdata=00000037",
                     got_lat, got_err, got_rdata, LAT);
        end
        total++;
        if (ready_low !== 1'b1) begin
            bad++;
            $display("FAIL read_ready_low: got %b want 1", ready_low);
        end
    endtask

    task automatic test_errors;
        logic [31:0] addrs [4];
        logic        wes   [4];
        logic [31:0] v;
        addrs = '{32'h2, 32'h400, 32'h400, 32'h3};
        wes   = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            issue(wes[i], addrs[i], 32'hFFFF_FFFF, 4'hF);
            total++;
            if (got_lat !== LAT || got_err !== 1'b1 || got_rdata !== 32'h0) begin
                bad++;
                $display("FAIL err_resp[%0d]: got lat=%0d err=%b rdata=%h want lat=%0d err=1 rdata=0",
                         i, got_lat, got_err, got_rdata, LAT);
            end
        end
        peek(8'd0, v);
        total++;
        if (v !== 32'h37) begin
            bad++;
            $display("FAIL err_mem0: got %h want 00000037", v);
        end
    endtask

    task automatic test_byte_write;
        logic [31:0] v;
        issue(1'b1, 32'h4, 32'h11223344, 4'hF);
        issue(1'b1, 32'h4, 32'hAABBCCDD, 4'b0101);
        total++;
        if (got_err !== 1'b0) begin
            bad++;
            $display("FAIL bw_err: got %b want 0", got_err);
        end
        peek(8'd1, v);
        total++;
        if (v !== EXP_M1) begin
            bad++;
            $display("FAIL bw_mem1: got %h want %h", v, EXP_M1);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        logic [31:0] v;
        int          lat;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h4;
        req_be     = 4'hF;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        // Keep offering a write to word 0 while busy; it must be ignored.
        req_we    = 1'b1;
        req_addr  = 32'h0;
        req_wdata = 32'h55;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (resp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        held = resp_rdata;
        total++;
        if (lat !== LAT || held !== EXP_M1) begin
            bad++;
            $display("FAIL bp_first: got lat=%0d rdata=%h want lat=%0d rdata=%h",
                     lat, held, LAT, EXP_M1);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== EXP_M1 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h ready=%b want 1/%h/0",
                         k, resp_valid, resp_rdata, req_ready, EXP_M1);
            end
        end
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got ready=%b valid=%b want 1/0", req_ready, resp_valid);
        end
        peek(8'd0, v);
        total++;
        if (v !== 32'h37) begin
            bad++;
            $display("FAIL bp_no_accept: got mem0=%h want 00000037", v);
        end
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] v;
        issue(1'b1, 32'h8, 32'h12345678, 4'hF);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h8;
            req_wdata = 32'hDEADBEEF;
            req_be    = 4'hF;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            // r=0: reset lands mid-WAIT; r=1: reset lands on the RESP-entry edge.
            if (r == 1) begin
                @(posedge clk);
                #1;
            end
            n_reset = 1'b0;
            @(posedge clk);
            #1;
            total++;
            if (resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_valid[%0d]: got %b want 0", r, resp_valid);
            end
            n_reset = 1'b1;
            @(posedge clk);
            #1;
            total++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_ready[%0d]: got ready=%b valid=%b want 1/0",
                         r, req_ready, resp_valid);
            end
            peek(8'd2, v);
            total++;
            if (v !== 32'h12345678) begin
                bad++;
                $display("FAIL rst_mem2[%0d]: got %h want 12345678", r, v);
            end
        end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF);
        issue(1'b0, 32'h3FC, 32'h0, 4'hF);
        total++;
        if (got_lat !== LAT || got_err !== 1'b0 || got_rdata !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL b2b_top_word: got lat=%0d err=%b rdata=%h want lat=%0d err=0 rdata=cafef00d",
                     got_lat, got_err, got_rdata, LAT);
        end
        issue(1'b0, 32'h8, 32'h0, 4'hF);
        total++;
        if (got_rdata !== 32'h12345678 || idle_after !== 1'b1) begin
            bad++;
            $display("FAIL b2b_mem2: got rdata=%h idle=%b want 12345678/1", got_rdata, idle_after);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_byte_write();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
